// File: rtl/board_io_pkg.sv
// Shared types and constants for board-input conditioning blocks.
package board_io_pkg;

  typedef enum logic [1:0] {
    ST_LO  = 2'd0,
    CHK_HI = 2'd1,
    ST_HI  = 2'd2,
    CHK_LO = 2'd3
  } debounce_state_e;

  localparam int DEBOUNCE_10MS_100MHZ = 1_000_000;

endpackage

// File: rtl/board_input_conditioner_if.sv
// Pin-side input and conditioned outputs of one board input.
interface board_input_conditioner_if;
  logic pin_i;
  logic level_o;
  logic rise_o;
  logic fall_o;
  logic rst_req_o;

  modport master (
    output pin_i,
    input  level_o, rise_o, fall_o, rst_req_o
  );

  modport slave (
    input  pin_i,
    output level_o, rise_o, fall_o, rst_req_o
  );
endinterface

// File: rtl/board_input_conditioner_sync_ff_chain.sv
// Multi-flop synchroniser for a single asynchronous input bit.
module sync_ff_chain #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= {STAGES{RESET_VAL}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/board_input_conditioner.sv
// Synchronises, debounces and edge-detects one board pin; stretches a reset request.
module board_input_conditioner
  import board_io_pkg::*;
#(
  parameter int   SYNC_STAGES     = 2,
  parameter int   DEBOUNCE_CYCLES = DEBOUNCE_10MS_100MHZ,
  parameter int   MIN_RST_CYCLES  = 16,
  parameter logic RESET_LEVEL     = 1'b1
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  board_input_conditioner_if.slave  bus
);

  localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_W = $clog2(MIN_RST_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(MIN_RST_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
  localparam debounce_state_e   RESET_STATE = RESET_LEVEL ? ST_HI : ST_LO;

  if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 2 || MIN_RST_CYCLES < 1) begin : g_bad_params
    $error("board_input_conditioner: illegal parameter value");
  end

  logic            sample;
  debounce_state_e state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             level_q;
  logic             rise_q;
  logic             fall_q;
  logic             rst_req_q;
  logic [HOLD_W-1:0] hold_q;
  logic [HOLD_W-1:0] hold_d;
  logic             level_d;
  logic             accept_rise;
  logic             accept_fall;

  sync_ff_chain #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (RESET_LEVEL)
  ) u_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (bus.pin_i),
    .q_o   (sample)
  );

  // A change is accepted on the last sample of a full unbroken run.
  always_comb begin
    accept_rise = (state_q == CHK_HI) && sample  && (cnt_q == CNT_LAST);
    accept_fall = (state_q == CHK_LO) && !sample && (cnt_q == CNT_LAST);

    level_d = level_q;
    if (accept_rise) begin
      level_d = 1'b1;
    end else if (accept_fall) begin
      level_d = 1'b0;
    end

    hold_d = hold_q;
    if (accept_rise) begin
      hold_d = HOLD_LOAD;
    end else if (hold_q != '0) begin
      hold_d = hold_q - HOLD_ONE;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= RESET_STATE;
      cnt_q   <= '0;
      level_q <= RESET_LEVEL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      rise_q  <= accept_rise;
      fall_q  <= accept_fall;
      level_q <= level_d;
      case (state_q)
        ST_LO: begin
          if (sample) begin
            state_q <= CHK_HI;
            cnt_q   <= CNT_ONE;
          end else begin
            cnt_q   <= '0;
          end
        end
        CHK_HI: begin
          if (!sample) begin
            state_q <= ST_LO;
            cnt_q   <= '0;
          end else if (accept_rise) begin
            state_q <= ST_HI;
            cnt_q   <= '0;
          end else begin
            cnt_q   <= cnt_q + CNT_ONE;
          end
        end
        ST_HI: begin
          if (!sample) begin
            state_q <= CHK_LO;
            cnt_q   <= CNT_ONE;
          end else begin
            cnt_q   <= '0;
          end
        end
        CHK_LO: begin
          if (sample) begin
            state_q <= ST_HI;
            cnt_q   <= '0;
          end else if (accept_fall) begin
            state_q <= ST_LO;
            cnt_q   <= '0;
          end else begin
            cnt_q   <= cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_q <= RESET_STATE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hold_q    <= '0;
      rst_req_q <= RESET_LEVEL;
    end else begin
      hold_q    <= hold_d;
      rst_req_q <= level_d | (hold_d != '0);
    end
  end

  assign bus.level_o   = level_q;
  assign bus.rise_o    = rise_q;
  assign bus.fall_o    = fall_q;
  assign bus.rst_req_o = rst_req_q;

endmodule
